msg_out_fifo: RTL and testbench
===============================

Name: msg_out_fifo

Overview:
- Downstream stage of the message parser. Captures each single-cycle message pulse (valid, length, data, error) into a small FIFO of whole messages.
- Presents messages to the consumer over a valid/ready handshake, which adds the backpressure the parser output lacks.
- Sanitises each message: masks bytes beyond the stated length and flags illegal lengths.
- Drops messages that arrive while the FIFO is full, and counts those drops.

Parameters:
- MAX_MSG_BYTES, 32, message data width in bytes; must match the parser.
- DEPTH, 4, number of message slots; power of two, 2..16.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- msg_valid  in  1  one-cycle pulse; message fields valid this cycle.
- msg_length  in  16  message length in bytes.
- msg_data  in  8*MAX_MSG_BYTES  message bytes, byte 0 on [7:0].
- msg_error  in  1  parser error flag for this message.
- out_valid  out  1  head message available.
- out_ready  in  1  consumer accepts the head message.
- out_length  out  16  head message length.
- out_data  out  8*MAX_MSG_BYTES  head message data, masked.
- out_error  out  1  head message error (parser error or illegal length).
- fifo_count  out  $clog2(DEPTH)+1  occupied slots.
- overflow  out  1  one-cycle pulse, the cycle after a message is dropped.
- drop_count  out  DROP_CNT_W  saturating count of dropped messages.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high, and wins over all other inputs in its cycle.
- Reset values: out_valid=0, out_length=0, out_data=0, out_error=0, fifo_count=0, overflow=0, drop_count=0, write/read pointers=0. Slot contents are not reset.
- Storage:
  - DEPTH register slots, each holding {length, data, error}.
  - Write and read pointers of width $clog2(DEPTH) wrap naturally.
  - Occupancy is a count register of width $clog2(DEPTH)+1.
- Write side, msg_valid=1:
  - If not full, or full with a read happening the same cycle (out_valid & out_ready): store the sanitised message in slot wr_ptr, then wr_ptr++.
  - Otherwise drop the message: overflow=1 next cycle, drop_count increments and saturates at all-ones.
- Sanitise, combinational, before the write:
  - bad_len = (msg_length==0) or (msg_length>MAX_MSG_BYTES).
  - Stored error = msg_error | bad_len. Stored length = msg_length unchanged.
  - Data: byte i is kept if i < msg_length, otherwise forced to 0. When msg_length > MAX_MSG_BYTES all bytes are kept.
- Read side (first-word-fall-through):
  - out_valid = (count != 0).
  - out_length, out_data and out_error come directly from slot rd_ptr when out_valid=1, and are forced to 0 when empty.
  - On out_valid & out_ready: rd_ptr++.
  - out_ready while empty is ignored.
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Latency: a message written in cycle N shows out_valid=1 in cycle N+1 (empty FIFO). There is no combinational path from msg_* to out_*.
- Count update: count +1 on write only, -1 on read only, unchanged when both or neither happen.
- Boundaries:
  - Full with simultaneous read and write: both happen, count stays at DEPTH, no drop.
  - Empty with write: count goes to 1, nothing is read.
  - Pointer wrap at DEPTH-1 → 0.
  - msg_valid asserted on consecutive cycles is legal; each cycle is a separate message.
  - Reset mid-stream discards all contents. A msg_valid in the reset cycle is not stored and not counted.
- fifo_count mirrors the count register.

Optional Feature:
- Macro: MSG_OUT_FIFO_DROP_ERR_EN.
- Defined:
  - Any message whose sanitised error is 1 is discarded at the write side and never enters the FIFO.
  - This discard is not an overflow: overflow stays 0 and drop_count is unchanged.
  - out_error is tied to 0.
- Undefined: errored messages are stored and delivered with out_error=1, as described under Behaviour.

Test Plan:
- Single message: reset, then msg_valid with length=5, data=32'hAABBCCDD plus byte4=0xEE and bytes5..31=0xFF → next cycle out_valid=1, out_length=5, bytes0..4 unchanged, bytes5..31=0, out_error=0. With out_ready=1 the following cycle → out_valid=0, fifo_count=0.
- Fill and overflow: DEPTH=4, out_ready=0, 5 messages on consecutive cycles → fifo_count=4, overflow pulses once the cycle after message 5, drop_count=1. Draining returns messages 1-4 in order.
- Full with simultaneous read and write: FIFO full, out_ready=1 and msg_valid=1 in the same cycle → no drop, fifo_count stays 4, the new message is delivered last.
- Illegal lengths: length=0, then length=33, then length=20 with msg_error=1.
  - Macro undefined → all three delivered with out_error=1; the length-33 message has all data bytes unmasked.
  - Macro defined → none delivered, drop_count=0.
- Wrap and stall: 10 messages streamed with out_ready toggling 1,0,1,0 → all 10 delivered in order, each held stable during stalls, no overflow.
- Reset mid-operation: 3 messages stored, rst=1 for one cycle while msg_valid=1 → out_valid=0, fifo_count=0, drop_count=0 the next cycle.

Source files
------------

// File: rtl/msg_out_fifo.sv
// msg_out_fifo: captures single-cycle parser message pulses into a small
// FWFT FIFO of whole messages, sanitising length/data on the way in, and
// presents them over valid/ready. Messages arriving while full are dropped
// and counted.
// Optional build macro MSG_OUT_FIFO_DROP_ERR_EN: discard errored messages at
// the write side and tie out_error low.
module msg_out_fifo #(
    parameter int MAX_MSG_BYTES = 32,
    parameter int DEPTH         = 4,
    parameter int DROP_CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       msg_valid,
    input  logic [15:0]                msg_length,
    input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
    input  logic                       msg_error,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_length,
    output logic [8*MAX_MSG_BYTES-1:0] out_data,
    output logic                       out_error,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic [DROP_CNT_W-1:0]      drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 8 * MAX_MSG_BYTES;

    typedef struct packed {
        logic [15:0]   length;
        logic [DW-1:0] data;
        logic          error;
    } slot_t;

    slot_t         mem [DEPTH];
    slot_t         san;
    slot_t         head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          bad_len, full, rd, wr, drop, discard;

    // Sanitise the incoming message: flag illegal lengths, zero bytes past the length
    always_comb begin
        bad_len    = (msg_length == 16'd0) || (msg_length > 16'(MAX_MSG_BYTES));
        san.length = msg_length;
        san.error  = msg_error | bad_len;
        san.data   = '0;
        for (int i = 0; i < MAX_MSG_BYTES; i++) begin
            // An over-long length means the whole data word is meaningful
            if (msg_length > 16'(MAX_MSG_BYTES) || 16'(i) < msg_length)
                san.data[8*i +: 8] = msg_data[8*i +: 8];
        end
    end

    // Write/read/drop decisions; a read in the same cycle frees the slot for a full write
    always_comb begin
        full = (count == CW'(DEPTH));
        rd   = out_valid & out_ready;
`ifdef MSG_OUT_FIFO_DROP_ERR_EN
        discard = san.error;
`else
        discard = 1'b0;
`endif
        wr   = ~rst & msg_valid & ~discard & (~full | rd);
        drop = msg_valid & ~discard & full & ~rd;
    end

    // Slot storage; contents survive reset, only the pointers are cleared
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= san;
    end

    // Pointers, occupancy, and drop accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow <= drop;
            if (drop && drop_count != {DROP_CNT_W{1'b1}})
                drop_count <= drop_count + 1'b1;
        end
    end

    // First-word-fall-through head presentation, zeroed while empty
    always_comb begin
        head       = mem[rd_ptr];
        out_valid  = (count != '0);
        out_length = '0;
        out_data   = '0;
        out_error  = 1'b0;
        if (out_valid) begin
            out_length = head.length;
            out_data   = head.data;
`ifndef MSG_OUT_FIFO_DROP_ERR_EN
            out_error  = head.error;
`endif
        end
    end

    assign fifo_count = count;
endmodule

// File: tb/tb_msg_out_fifo.sv
// Scoreboard bench for msg_out_fifo: stimulus pushes expected messages into a
// queue from a queue-level reference model; a negedge monitor pops and
// compares on every handshake and checks occupancy/drop status every cycle.
module tb_msg_out_fifo;
    localparam int MB    = 32;
    localparam int DEPTH = 4;
    localparam int DCW   = 16;
    localparam int DW    = 8 * MB;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           msg_valid = 1'b0;
    logic [15:0]    msg_length = '0;
    logic [DW-1:0]  msg_data = '0;
    logic           msg_error = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [15:0]    out_length;
    logic [DW-1:0]  out_data;
    logic           out_error;
    logic [2:0]     fifo_count;
    logic           overflow;
    logic [DCW-1:0] drop_count;

    msg_out_fifo #(.MAX_MSG_BYTES(MB), .DEPTH(DEPTH), .DROP_CNT_W(DCW)) dut (
        .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_length(msg_length),
        .msg_data(msg_data), .msg_error(msg_error), .out_valid(out_valid),
        .out_ready(out_ready), .out_length(out_length), .out_data(out_data),
        .out_error(out_error), .fifo_count(fifo_count), .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]   len;
        logic [DW-1:0] data;
        logic          err;
    } msg_t;

    msg_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   mcnt = 0;
    int   mdrop = 0;
    bit   mover = 0;
    bit   started = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic msg_t sanitize(input logic [15:0] len, input logic [DW-1:0] d, input logic e);
        msg_t r;
        r.len  = len;
        r.err  = e | (len == 0) | (len > MB);
        r.data = '0;
        for (int i = 0; i < MB; i++)
            if (len > MB || i < len) r.data[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // One clock of stimulus; the model decides acceptance from queue occupancy
    task automatic cycle(input bit v, input logic [15:0] len, input logic [DW-1:0] d,
                         input bit e, input bit rdy);
        msg_t s;
        bit   rd, wr, drp, disc;
        msg_valid = v; msg_length = len; msg_data = d; msg_error = e; out_ready = rdy;
        rd = (mcnt > 0) && rdy;
        wr = 0; drp = 0;
        if (v) begin
            s = sanitize(len, d, e);
            disc = 0;
`ifdef MSG_OUT_FIFO_DROP_ERR_EN
            disc = s.err;
`endif
            if (!disc) begin
                if (mcnt < DEPTH || rd) begin exp_q.push_back(s); wr = 1; end
                else drp = 1;
            end
        end
        @(posedge clk); #1;
        mcnt  = mcnt + int'(wr) - int'(rd);
        mover = drp;
        if (drp && mdrop != 65535) mdrop++;
        msg_valid = 0;
    endtask

    task automatic do_reset(input bit with_msg);
        rst = 1; msg_valid = with_msg; msg_length = 16'd4; msg_data = rand_data();
        msg_error = 0; out_ready = 0;
        @(posedge clk); #1;
        rst = 0; msg_valid = 0;
        mcnt = 0; mdrop = 0; mover = 0;
        exp_q.delete();
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && mcnt > 0; k++) cycle(0, 0, '0, 0, 1);
        cycle(0, 0, '0, 0, 0);
        check("drained", DW'(exp_q.size()), '0);
    endtask

    // Monitor: status every cycle, payload on handshake, stability during stalls
    msg_t hold;
    bit   hold_pend = 0;
    always @(negedge clk) begin
        msg_t m;
        if (started && !rst) begin
            check("fifo_count", DW'(fifo_count), DW'(mcnt));
            check("overflow", DW'(overflow), DW'(mover));
            check("drop_count", DW'(drop_count), DW'(mdrop));
            check("out_valid", DW'(out_valid), DW'(mcnt != 0));
            if (!out_valid) begin
                check("empty_zero", DW'(out_length) | out_data | DW'(out_error), '0);
                hold_pend = 0;
            end else begin
                if (hold_pend) begin
                    check("stall_len", DW'(out_length), DW'(hold.len));
                    check("stall_data", out_data, hold.data);
                    check("stall_err", DW'(out_error), DW'(hold.err));
                end
                if (out_ready) begin
                    hold_pend = 0;
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_msg actual=%h required=none", out_length);
                    end else begin
                        m = exp_q.pop_front();
                        check("out_length", DW'(out_length), DW'(m.len));
                        check("out_data", out_data, m.data);
                        check("out_error", DW'(out_error), DW'(m.err));
                    end
                end else begin
                    hold.len = out_length; hold.data = out_data; hold.err = out_error;
                    hold_pend = 1;
                end
            end
        end else hold_pend = 0;
    end

    initial begin
        logic [DW-1:0] d;
        bit t;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1);
        started = 1;
        cycle(0, 0, '0, 0, 0);

        // Single message with masking of bytes past length 5
        d = '1;
        d[39:0] = 40'hEE_AABBCCDD;
        cycle(1, 16'd5, d, 0, 0);
        cycle(0, 0, '0, 0, 0);
        cycle(0, 0, '0, 0, 1);
        cycle(0, 0, '0, 0, 0);

        // Fill and overflow on the fifth message
        for (int i = 0; i < 5; i++) cycle(1, 16'(i + 1), rand_data(), 0, 0);
        cycle(0, 0, '0, 0, 0);
        drain();

        // Full with simultaneous read and write
        for (int i = 0; i < 4; i++) cycle(1, 16'(8 + i), rand_data(), 0, 0);
        cycle(1, 16'd32, rand_data(), 0, 1);
        drain();

        // Illegal lengths and parser error
        cycle(1, 16'd0, rand_data(), 0, 0);
        cycle(1, 16'd33, rand_data(), 0, 0);
        cycle(1, 16'd20, rand_data(), 1, 0);
        cycle(0, 0, '0, 0, 0);
        drain();

        // Wrap and stall: out_ready toggles every cycle
        t = 1;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 16'($urandom_range(1, MB)), rand_data(), 0, t); t = ~t;
            cycle(0, 0, '0, 0, t); t = ~t;
        end
        drain();

        // Reset mid-stream with a message in the reset cycle
        for (int i = 0; i < 3; i++) cycle(1, 16'd7, rand_data(), 0, 0);
        do_reset(1);
        cycle(0, 0, '0, 0, 1);

        // Randomised traffic
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 16'($urandom_range(0, 40)), rand_data(),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
